// File: rtl/ysyx_25020037_axi_arbiter_pkg.sv
// Shared AXI field widths, arbiter state encoding and the grant-priority helper
// for the IFU/LSU AXI arbiter.
package ysyx_25020037_axi_arbiter_pkg;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int ID_W    = 4;
  localparam int LEN_W   = 8;
  localparam int SIZE_W  = 3;
  localparam int BURST_W = 2;
  localparam int RESP_W  = 2;
  localparam int STRB_W  = DATA_W / 8;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_IFU_R = 2'd1,
    ARB_LSU_R = 2'd2,
    ARB_LSU_W = 2'd3
  } arb_state_e;

  // A starved IFU overrides everything; otherwise LSU write > LSU read > IFU read.
  function automatic arb_state_e arb_pick(input logic ifu_starved,
                                          input logic m0_rreq,
                                          input logic m1_wreq,
                                          input logic m1_rreq);
    if (ifu_starved && m0_rreq) return ARB_IFU_R;
    else if (m1_wreq)           return ARB_LSU_W;
    else if (m1_rreq)           return ARB_LSU_R;
    else if (m0_rreq)           return ARB_IFU_R;
    else                        return ARB_IDLE;
  endfunction

endpackage

// File: rtl/ysyx_25020037_axi_arbiter.sv
// Shares the core-side AXI4 master port between IFU (m0, read-only) and LSU (m1).
// One transaction is granted at a time and the bus stays locked until its response completes.
module ysyx_25020037_axi_arbiter
  import ysyx_25020037_axi_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 3
) (
  input  logic               clk,
  input  logic               rst,

  input  logic               m0_arvalid,
  output logic               m0_arready,
  input  logic [ADDR_W-1:0]  m0_araddr,
  input  logic [ID_W-1:0]    m0_arid,
  input  logic [LEN_W-1:0]   m0_arlen,
  input  logic [SIZE_W-1:0]  m0_arsize,
  input  logic [BURST_W-1:0] m0_arburst,
  output logic               m0_rvalid,
  input  logic               m0_rready,
  output logic [DATA_W-1:0]  m0_rdata,
  output logic [RESP_W-1:0]  m0_rresp,
  output logic               m0_rlast,
  output logic [ID_W-1:0]    m0_rid,

  input  logic               m1_arvalid,
  output logic               m1_arready,
  input  logic [ADDR_W-1:0]  m1_araddr,
  input  logic [ID_W-1:0]    m1_arid,
  input  logic [LEN_W-1:0]   m1_arlen,
  input  logic [SIZE_W-1:0]  m1_arsize,
  input  logic [BURST_W-1:0] m1_arburst,
  output logic               m1_rvalid,
  input  logic               m1_rready,
  output logic [DATA_W-1:0]  m1_rdata,
  output logic [RESP_W-1:0]  m1_rresp,
  output logic               m1_rlast,
  output logic [ID_W-1:0]    m1_rid,
  input  logic               m1_awvalid,
  output logic               m1_awready,
  input  logic [ADDR_W-1:0]  m1_awaddr,
  input  logic [ID_W-1:0]    m1_awid,
  input  logic [LEN_W-1:0]   m1_awlen,
  input  logic [SIZE_W-1:0]  m1_awsize,
  input  logic [BURST_W-1:0] m1_awburst,
  input  logic               m1_wvalid,
  output logic               m1_wready,
  input  logic [DATA_W-1:0]  m1_wdata,
  input  logic [STRB_W-1:0]  m1_wstrb,
  input  logic               m1_wlast,
  output logic               m1_bvalid,
  input  logic               m1_bready,
  output logic [RESP_W-1:0]  m1_bresp,
  output logic [ID_W-1:0]    m1_bid,

  output logic               s_arvalid,
  input  logic               s_arready,
  output logic [ADDR_W-1:0]  s_araddr,
  output logic [ID_W-1:0]    s_arid,
  output logic [LEN_W-1:0]   s_arlen,
  output logic [SIZE_W-1:0]  s_arsize,
  output logic [BURST_W-1:0] s_arburst,
  input  logic               s_rvalid,
  output logic               s_rready,
  input  logic [DATA_W-1:0]  s_rdata,
  input  logic [RESP_W-1:0]  s_rresp,
  input  logic               s_rlast,
  input  logic [ID_W-1:0]    s_rid,
  output logic               s_awvalid,
  input  logic               s_awready,
  output logic [ADDR_W-1:0]  s_awaddr,
  output logic [ID_W-1:0]    s_awid,
  output logic [LEN_W-1:0]   s_awlen,
  output logic [SIZE_W-1:0]  s_awsize,
  output logic [BURST_W-1:0] s_awburst,
  output logic               s_wvalid,
  input  logic               s_wready,
  output logic [DATA_W-1:0]  s_wdata,
  output logic [STRB_W-1:0]  s_wstrb,
  output logic               s_wlast,
  input  logic               s_bvalid,
  output logic               s_bready,
  input  logic [RESP_W-1:0]  s_bresp,
  input  logic [ID_W-1:0]    s_bid
);

  arb_state_e       state;
  arb_state_e       next_grant;
  logic [CNT_W-1:0] wait_cnt;
  logic             gnt_ifu, gnt_lsu_r, gnt_lsu_w;
  logic             ar_done, aw_done, w_done;
  logic             ifu_starved;

  assign ifu_starved = (wait_cnt == CNT_W'(MAX_WAIT));
  assign next_grant  = arb_pick(ifu_starved, m0_arvalid, m1_awvalid, m1_arvalid);

  // The done flags close each address/data channel once it has handshaken, so a
  // master that keeps its valid high cannot slip a second transaction onto the bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ARB_IDLE;
      wait_cnt  <= '0;
      gnt_ifu   <= 1'b0;
      gnt_lsu_r <= 1'b0;
      gnt_lsu_w <= 1'b0;
      ar_done   <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
    end else begin
      unique case (state)
        ARB_IDLE: begin
          state     <= next_grant;
          gnt_ifu   <= (next_grant == ARB_IFU_R);
          gnt_lsu_r <= (next_grant == ARB_LSU_R);
          gnt_lsu_w <= (next_grant == ARB_LSU_W);
          if (next_grant == ARB_IFU_R)
            wait_cnt <= '0;
          else if (m0_arvalid && !ifu_starved)
            wait_cnt <= wait_cnt + 1'b1;
        end
        ARB_IFU_R, ARB_LSU_R: begin
          if (s_arvalid && s_arready)
            ar_done <= 1'b1;
          if (s_rvalid && s_rready && s_rlast) begin
            state     <= ARB_IDLE;
            gnt_ifu   <= 1'b0;
            gnt_lsu_r <= 1'b0;
            ar_done   <= 1'b0;
          end
        end
        ARB_LSU_W: begin
          if (s_awvalid && s_awready)
            aw_done <= 1'b1;
          if (s_wvalid && s_wready && s_wlast)
            w_done <= 1'b1;
          if (s_bvalid && s_bready) begin
            state     <= ARB_IDLE;
            gnt_lsu_w <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
          end
        end
      endcase
    end
  end

  // Handshake routing: only the grantee's valids/readys pass; B is held back until AW and W are both done.
  always_comb begin
    s_arvalid  = 1'b0;
    s_rready   = 1'b0;
    s_awvalid  = 1'b0;
    s_wvalid   = 1'b0;
    s_bready   = 1'b0;
    m0_arready = 1'b0;
    m0_rvalid  = 1'b0;
    m1_arready = 1'b0;
    m1_rvalid  = 1'b0;
    m1_awready = 1'b0;
    m1_wready  = 1'b0;
    m1_bvalid  = 1'b0;
    if (gnt_ifu) begin
      s_arvalid  = m0_arvalid & ~ar_done;
      m0_arready = s_arready & ~ar_done;
      m0_rvalid  = s_rvalid;
      s_rready   = m0_rready;
    end
    if (gnt_lsu_r) begin
      s_arvalid  = m1_arvalid & ~ar_done;
      m1_arready = s_arready & ~ar_done;
      m1_rvalid  = s_rvalid;
      s_rready   = m1_rready;
    end
    if (gnt_lsu_w) begin
      s_awvalid  = m1_awvalid & ~aw_done;
      m1_awready = s_awready & ~aw_done;
      s_wvalid   = m1_wvalid & ~w_done;
      m1_wready  = s_wready & ~w_done;
      m1_bvalid  = s_bvalid & aw_done & w_done;
      s_bready   = m1_bready & aw_done & w_done;
    end
  end

  assign s_araddr  = gnt_lsu_r ? m1_araddr  : m0_araddr;
  assign s_arid    = gnt_lsu_r ? m1_arid    : m0_arid;
  assign s_arlen   = gnt_lsu_r ? m1_arlen   : m0_arlen;
  assign s_arsize  = gnt_lsu_r ? m1_arsize  : m0_arsize;
  assign s_arburst = gnt_lsu_r ? m1_arburst : m0_arburst;

  assign s_awaddr  = m1_awaddr;
  assign s_awid    = m1_awid;
  assign s_awlen   = m1_awlen;
  assign s_awsize  = m1_awsize;
  assign s_awburst = m1_awburst;
  assign s_wdata   = m1_wdata;
  assign s_wstrb   = m1_wstrb;
  assign s_wlast   = m1_wlast;

  assign m0_rdata = s_rdata;
  assign m0_rresp = s_rresp;
  assign m0_rlast = s_rlast;
  assign m0_rid   = s_rid;
  assign m1_rdata = s_rdata;
  assign m1_rresp = s_rresp;
  assign m1_rlast = s_rlast;
  assign m1_rid   = s_rid;
  assign m1_bresp = s_bresp;
  assign m1_bid   = s_bid;

endmodule

// File: tb/tb_ysyx_25020037_axi_arbiter.sv
// Directed bench for the IFU/LSU AXI arbiter: a bus-ownership model checks every
// handshake and routed payload each cycle, and literal checks pin key scenarios.
module tb_ysyx_25020037_axi_arbiter;

  localparam int MAX_WAIT  = 4;
  localparam int OWN_NONE  = 0;
  localparam int OWN_IFU   = 1;
  localparam int OWN_LSU_R = 2;
  localparam int OWN_LSU_W = 3;

  logic clk, rst;
  logic m0_arvalid, m0_arready, m0_rvalid, m0_rready, m0_rlast;
  logic [31:0] m0_araddr, m0_rdata;
  logic [3:0]  m0_arid, m0_rid;
  logic [7:0]  m0_arlen;
  logic [2:0]  m0_arsize;
  logic [1:0]  m0_arburst, m0_rresp;
  logic m1_arvalid, m1_arready, m1_rvalid, m1_rready, m1_rlast;
  logic [31:0] m1_araddr, m1_rdata;
  logic [3:0]  m1_arid, m1_rid;
  logic [7:0]  m1_arlen;
  logic [2:0]  m1_arsize;
  logic [1:0]  m1_arburst, m1_rresp;
  logic m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_wlast, m1_bvalid, m1_bready;
  logic [31:0] m1_awaddr, m1_wdata;
  logic [3:0]  m1_awid, m1_wstrb, m1_bid;
  logic [7:0]  m1_awlen;
  logic [2:0]  m1_awsize;
  logic [1:0]  m1_awburst, m1_bresp;
  logic s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
  logic [31:0] s_araddr, s_rdata;
  logic [3:0]  s_arid, s_rid;
  logic [7:0]  s_arlen;
  logic [2:0]  s_arsize;
  logic [1:0]  s_arburst, s_rresp;
  logic s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;
  logic [31:0] s_awaddr, s_wdata;
  logic [3:0]  s_awid, s_wstrb, s_bid;
  logic [7:0]  s_awlen;
  logic [2:0]  s_awsize;
  logic [1:0]  s_awburst, s_bresp;

  int total = 0;
  int bad   = 0;

  ysyx_25020037_axi_arbiter #(.MAX_WAIT(MAX_WAIT), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr), .m0_arid(m0_arid),
    .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_arburst(m0_arburst),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
    .m0_rlast(m0_rlast), .m0_rid(m0_rid),
    .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr), .m1_arid(m1_arid),
    .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_arburst(m1_arburst),
    .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
    .m1_rlast(m1_rlast), .m1_rid(m1_rid),
    .m1_awvalid(m1_awvalid), .m1_awready(m1_awready), .m1_awaddr(m1_awaddr), .m1_awid(m1_awid),
    .m1_awlen(m1_awlen), .m1_awsize(m1_awsize), .m1_awburst(m1_awburst),
    .m1_wvalid(m1_wvalid), .m1_wready(m1_wready), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_wlast(m1_wlast), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready), .m1_bresp(m1_bresp),
    .m1_bid(m1_bid),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rlast(s_rlast), .s_rid(s_rid),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awid(s_awid),
    .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_wlast(s_wlast), .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp), .s_bid(s_bid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clearInputs();
    m0_arvalid = 0; m0_araddr = '0; m0_arid = '0; m0_arlen = '0; m0_arsize = 3'd2; m0_arburst = 2'b01;
    m0_rready = 0;
    m1_arvalid = 0; m1_araddr = '0; m1_arid = '0; m1_arlen = '0; m1_arsize = 3'd2; m1_arburst = 2'b01;
    m1_rready = 0;
    m1_awvalid = 0; m1_awaddr = '0; m1_awid = '0; m1_awlen = '0; m1_awsize = 3'd2; m1_awburst = 2'b01;
    m1_wvalid = 0; m1_wdata = '0; m1_wstrb = '0; m1_wlast = 0; m1_bready = 0;
    s_arready = 0; s_rvalid = 0; s_rdata = '0; s_rresp = '0; s_rlast = 0; s_rid = '0;
    s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = '0; s_bid = '0;
  endtask

  // Ownership model: who holds the bus, which address/data phases are finished, IFU losses so far.
  int   m_owner = OWN_NONE;
  int   m_starve = 0;
  logic m_ar_seen = 0, m_aw_seen = 0, m_w_seen = 0;

  always @(negedge clk) begin
    logic [11:0] exp_ctrl, act_ctrl;
    logic own_arvalid, own_rready, both;
    if (rst) begin
      m_owner = OWN_NONE; m_starve = 0;
      m_ar_seen = 0; m_aw_seen = 0; m_w_seen = 0;
    end
    own_arvalid = (m_owner == OWN_IFU) ? m0_arvalid : m1_arvalid;
    own_rready  = (m_owner == OWN_IFU) ? m0_rready  : m1_rready;
    both        = m_aw_seen && m_w_seen;
    // bit order: m0_arready m0_rvalid m1_arready m1_rvalid m1_awready m1_wready m1_bvalid
    //            s_arvalid s_rready s_awvalid s_wvalid s_bready
    exp_ctrl = '0;
    if (m_owner == OWN_IFU)
      exp_ctrl = {s_arready && !m_ar_seen, s_rvalid, 5'b0, m0_arvalid && !m_ar_seen, m0_rready, 3'b0};
    else if (m_owner == OWN_LSU_R)
      exp_ctrl = {2'b0, s_arready && !m_ar_seen, s_rvalid, 3'b0, m1_arvalid && !m_ar_seen, m1_rready, 3'b0};
    else if (m_owner == OWN_LSU_W)
      exp_ctrl = {4'b0, s_awready && !m_aw_seen, s_wready && !m_w_seen, s_bvalid && both, 2'b0,
                  m1_awvalid && !m_aw_seen, m1_wvalid && !m_w_seen, m1_bready && both};
    act_ctrl = {m0_arready, m0_rvalid, m1_arready, m1_rvalid, m1_awready, m1_wready, m1_bvalid,
                s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready};
    checkOutput("model handshakes", {20'b0, act_ctrl}, {20'b0, exp_ctrl});
    checkOutput("model wait_cnt", {29'b0, dut.wait_cnt}, m_starve);
    if (exp_ctrl[4])
      checkOutput("model s_araddr", s_araddr, (m_owner == OWN_IFU) ? m0_araddr : m1_araddr);
    if (exp_ctrl[10])
      checkOutput("model m0_rdata", m0_rdata, s_rdata);
    if (exp_ctrl[8])
      checkOutput("model m1_rdata", m1_rdata, s_rdata);
    if (exp_ctrl[5])
      checkOutput("model m1_bresp", {30'b0, m1_bresp}, {30'b0, s_bresp});
    if (!rst) begin
      case (m_owner)
        OWN_NONE: begin
          if (m0_arvalid && m_starve == MAX_WAIT) m_owner = OWN_IFU;
          else if (m1_awvalid)                    m_owner = OWN_LSU_W;
          else if (m1_arvalid)                    m_owner = OWN_LSU_R;
          else if (m0_arvalid)                    m_owner = OWN_IFU;
          if (m_owner == OWN_IFU)  m_starve = 0;
          else if (m0_arvalid)     m_starve = (m_starve < MAX_WAIT) ? m_starve + 1 : MAX_WAIT;
        end
        OWN_IFU, OWN_LSU_R: begin
          if (own_arvalid && s_arready) m_ar_seen = 1;
          if (s_rvalid && own_rready && s_rlast) begin
            m_owner = OWN_NONE; m_ar_seen = 0;
          end
        end
        default: begin
          if (both && s_bvalid && m1_bready) begin
            m_owner = OWN_NONE; m_aw_seen = 0; m_w_seen = 0;
          end else begin
            if (m1_awvalid && s_awready) m_aw_seen = 1;
            if (m1_wvalid && s_wready && m1_wlast) m_w_seen = 1;
          end
        end
      endcase
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    clearInputs();
    applyStimulus(2);
    settle();
    checkOutput("reset s_arvalid", {31'b0, s_arvalid}, 0);
    checkOutput("reset m1_awready", {31'b0, m1_awready}, 0);
    checkOutput("reset wait_cnt", {29'b0, dut.wait_cnt}, 0);
    rst = 1'b0;
    applyStimulus(1);

    $display("[TB] scenario 1: IFU single read");
    m0_arvalid = 1; m0_araddr = 32'h3000_0000; m0_arid = 4'h5;
    settle();
    checkOutput("t1 no AR in request cycle", {31'b0, s_arvalid}, 0);
    applyStimulus(1);
    settle();
    checkOutput("t1 AR forwarded", {31'b0, s_arvalid}, 1);
    checkOutput("t1 araddr", s_araddr, 32'h3000_0000);
    s_arready = 1;
    applyStimulus(1);
    m0_arvalid = 0; s_arready = 0; m0_rready = 1;
    s_rvalid = 1; s_rdata = 32'hDEAD_BEEF; s_rlast = 1; s_rid = 4'h5;
    settle();
    checkOutput("t1 m0_rvalid", {31'b0, m0_rvalid}, 1);
    checkOutput("t1 m0_rdata", m0_rdata, 32'hDEAD_BEEF);
    checkOutput("t1 m0_rid", {28'b0, m0_rid}, 5);
    applyStimulus(1);
    s_rvalid = 0; s_rlast = 0; m0_rready = 0;
    settle();
    checkOutput("t1 idle after rlast", {31'b0, m0_rvalid}, 0);
    applyStimulus(1);

    $display("[TB] scenario 2: simultaneous reads, LSU first");
    m0_arvalid = 1; m0_araddr = 32'h3000_0010;
    m1_arvalid = 1; m1_araddr = 32'h8000_0000;
    applyStimulus(1);
    settle();
    checkOutput("t2 LSU AR first", s_araddr, 32'h8000_0000);
    checkOutput("t2 IFU blocked", {31'b0, m0_arready}, 0);
    s_arready = 1;
    applyStimulus(1);
    m1_arvalid = 0; s_arready = 0; m1_rready = 1;
    s_rvalid = 1; s_rdata = 32'h1234_5678; s_rlast = 1;
    settle();
    checkOutput("t2 m1_rdata", m1_rdata, 32'h1234_5678);
    checkOutput("t2 no IFU AR during LSU R", {31'b0, s_arvalid}, 0);
    applyStimulus(1);
    s_rvalid = 0; s_rlast = 0; m1_rready = 0;
    settle();
    checkOutput("t2 idle gap", {31'b0, s_arvalid}, 0);
    applyStimulus(1);
    settle();
    checkOutput("t2 IFU AR after gap", {31'b0, s_arvalid}, 1);
    checkOutput("t2 IFU araddr", s_araddr, 32'h3000_0010);
    s_arready = 1;
    applyStimulus(1);
    m0_arvalid = 0; s_arready = 0; m0_rready = 1; s_rvalid = 1; s_rlast = 1;
    applyStimulus(1);
    clearInputs();
    applyStimulus(1);

    $display("[TB] scenario 3: anti-starvation");
    m0_arvalid = 1; m0_araddr = 32'h3000_0100;
    m1_arvalid = 1; m1_araddr = 32'h8000_0100;
    s_arready = 1; m0_rready = 1; m1_rready = 1; s_rlast = 1;
    for (int r = 1; r <= 5; r++) begin
      applyStimulus(1);
      settle();
      checkOutput($sformatf("t3 round %0d LSU grant", r), {31'b0, m1_arready}, (r < 5) ? 1 : 0);
      checkOutput($sformatf("t3 round %0d IFU grant", r), {31'b0, m0_arready}, (r == 5) ? 1 : 0);
      applyStimulus(1);
      s_rvalid = 1; s_rdata = 32'h100 + r;
      applyStimulus(1);
      s_rvalid = 0;
      if (r == 5) begin
        m0_arvalid = 0; m1_arvalid = 0;
      end
      settle();
      if (r == 4) checkOutput("t3 wait_cnt after 4 losses", {29'b0, dut.wait_cnt}, 4);
    end
    checkOutput("t3 wait_cnt after IFU grant", {29'b0, dut.wait_cnt}, 0);
    clearInputs();
    applyStimulus(1);

    $display("[TB] scenario 4: LSU write, W before AW");
    m1_awvalid = 1; m1_awaddr = 32'hA000_0004;
    m1_wvalid = 1; m1_wdata = 32'h0000_BEEF; m1_wstrb = 4'b0011; m1_wlast = 1; m1_bready = 1;
    applyStimulus(1);
    s_wready = 1;
    settle();
    checkOutput("t4 awaddr", s_awaddr, 32'hA000_0004);
    checkOutput("t4 wstrb", {28'b0, s_wstrb}, 4'b0011);
    checkOutput("t4 W accepted", {31'b0, m1_wready}, 1);
    applyStimulus(1);
    m1_wvalid = 0; s_wready = 0; s_bvalid = 1; s_bresp = 2'b10;
    settle();
    checkOutput("t4 B held, AW pending", {31'b0, m1_bvalid}, 0);
    applyStimulus(1);
    s_awready = 1;
    settle();
    checkOutput("t4 s_bready held", {31'b0, s_bready}, 0);
    applyStimulus(1);
    m1_awvalid = 0; s_awready = 0;
    settle();
    checkOutput("t4 B released", {31'b0, m1_bvalid}, 1);
    checkOutput("t4 s_bready released", {31'b0, s_bready}, 1);
    checkOutput("t4 bresp SLVERR", {30'b0, m1_bresp}, 2'b10);
    applyStimulus(1);
    clearInputs();
    settle();
    checkOutput("t4 idle after B", {31'b0, m1_bvalid}, 0);
    applyStimulus(1);

    $display("[TB] scenario 5: IFU burst holds the bus");
    m0_arvalid = 1; m0_araddr = 32'hA000_0000; m0_arlen = 8'd3;
    applyStimulus(1);
    s_arready = 1;
    settle();
    checkOutput("t5 arlen", {24'b0, s_arlen}, 3);
    applyStimulus(1);
    m0_arvalid = 0; s_arready = 0; m0_rready = 1;
    m1_arvalid = 1; m1_araddr = 32'h8000_0200;
    for (int b = 0; b < 4; b++) begin
      s_rvalid = 1; s_rdata = 32'hC0DE_0000 + b; s_rlast = (b == 3);
      settle();
      checkOutput($sformatf("t5 beat %0d data", b), m0_rdata, 32'hC0DE_0000 + b);
      checkOutput($sformatf("t5 beat %0d LSU waits", b), {31'b0, s_arvalid}, 0);
      applyStimulus(1);
    end
    s_rvalid = 0; s_rlast = 0; m0_rready = 0;
    settle();
    checkOutput("t5 idle after burst", {31'b0, s_arvalid}, 0);
    applyStimulus(1);
    settle();
    checkOutput("t5 LSU AR after burst", s_araddr, 32'h8000_0200);
    s_arready = 1;
    applyStimulus(1);
    m1_arvalid = 0; s_arready = 0; m1_rready = 1; s_rvalid = 1; s_rlast = 1;
    applyStimulus(1);
    clearInputs();
    applyStimulus(1);

    $display("[TB] scenario 6: reset during LSU write");
    m1_awvalid = 1; m1_awaddr = 32'hA000_0008; m1_wvalid = 1; m1_wlast = 1; m1_bready = 1;
    applyStimulus(1);
    s_awready = 1;
    applyStimulus(1);
    m1_awvalid = 0; s_awready = 0;
    settle();
    checkOutput("t6 W still open", {31'b0, s_wvalid}, 1);
    s_wready = 1; s_rvalid = 1; s_bvalid = 1;
    rst = 1'b1;
    settle();
    checkOutput("t6 reset kills s_wvalid", {31'b0, s_wvalid}, 0);
    checkOutput("t6 reset kills m1_wready", {31'b0, m1_wready}, 0);
    checkOutput("t6 reset kills m1_bvalid", {31'b0, m1_bvalid}, 0);
    applyStimulus(2);
    clearInputs();
    rst = 1'b0;
    applyStimulus(1);
    m0_arvalid = 1; m0_araddr = 32'h3000_0200;
    applyStimulus(1);
    settle();
    checkOutput("t6 new grant after reset", {31'b0, s_arvalid}, 1);
    s_arready = 1;
    applyStimulus(1);
    m0_arvalid = 0; s_arready = 0; m0_rready = 1; s_rvalid = 1; s_rlast = 1;
    applyStimulus(1);
    clearInputs();
    applyStimulus(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
